mdu_ctrl: RTL

Multiply/divide unit controller for the pipelined MIPS core. It sits beside the ALU in the E stage and executes MULT, MULTU, DIV and DIVU with fixed multi-cycle latency. It owns the HI/LO architectural registers and services MFHI, MFLO, MTHI and MTLO. It raises a stall request whenever an MD-class instruction in E would observe an in-flight operation.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_arith.sv | 59 +++++
 rtl/mdu_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, cycle defaults
// and the helper that classifies an op as belonging to the MD unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8
    } md_op_t;

    typedef enum logic {
        CLS_MUL = 1'b0,
        CLS_DIV = 1'b1
    } md_cls_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    function automatic logic md_class(input logic [3:0] op);
        return (op >= 4'(MULT)) && (op <= 4'(MTLO));
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing the 64-bit {HI, LO}
// result and a divide-by-zero flag; non-arithmetic ops yield zero.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        div_by_zero
);

    logic [63:0] prod;
    logic [31:0] divisor;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        signed_div;

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
    assign signed_div  = (op == 4'(DIV));
    assign div_by_zero = (b == 32'd0);
    assign mag_a       = (signed_div && a[31]) ? (~a + 32'd1) : a;
    assign mag_b       = (signed_div && b[31]) ? (~b + 32'd1) : b;
    assign divisor     = div_by_zero ? 32'd1 : mag_b;

    always_comb begin
        prod    = 64'd0;
        quot    = 32'd0;
        rem     = 32'd0;
        hi_next = 32'd0;
        lo_next = 32'd0;
        case (op)
            4'(MULT): begin
                prod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                hi_next = prod[63:32];
                lo_next = prod[31:0];
            end
            4'(MULTU): begin
                prod    = {32'd0, a} * {32'd0, b};
                hi_next = prod[63:32];
                lo_next = prod[31:0];
            end
            4'(DIV), 4'(DIVU): begin
                quot    = mag_a / divisor;
                rem     = mag_a % divisor;
                lo_next = (signed_div && (a[31] ^ b[31])) ? (~quot + 32'd1) : quot;
                hi_next = (signed_div && a[31]) ? (~rem + 32'd1) : rem;
            end
            default: begin
                hi_next = 32'd0;
                lo_next = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences fixed-latency mult/div
// operations with a down-counter and stalls MD ops that would see them in flight.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall_req,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] count;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    md_cls_t          pend_cls;
    logic             pend_dbz;
    logic [31:0]      hi_next;
    logic [31:0]      lo_next;
    logic             div_by_zero;
    logic             is_md;
    logic             accept;
    logic             commit;

    mdu_arith u_arith (
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_next     (hi_next),
        .lo_next     (lo_next),
        .div_by_zero (div_by_zero)
    );

    assign is_md     = md_class(op);
    assign busy      = (count != '0);
    assign stall_req = req && is_md && busy;
    assign accept    = req && is_md && !busy;
    // A divide by zero still runs its full latency but never writes HI/LO.
    assign commit    = (count == CNT_W'(1)) && !((pend_cls == CLS_DIV) && pend_dbz);

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        rdata = 32'd0;
        if (op == 4'(MFHI))      rdata = hi_q;
        else if (op == 4'(MFLO)) rdata = lo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            pend_hi  <= 32'd0;
            pend_lo  <= 32'd0;
            pend_cls <= CLS_MUL;
            pend_dbz <= 1'b0;
        end else begin
            if (busy) begin
                count <= count - CNT_W'(1);
                if (commit) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end
            // accept implies !busy, so these never collide with the commit above.
            if (accept) begin
                case (op)
                    4'(MULT), 4'(MULTU): begin
                        pend_hi  <= hi_next;
                        pend_lo  <= lo_next;
                        pend_cls <= CLS_MUL;
                        pend_dbz <= 1'b0;
                        count    <= MULT_LOAD;
                    end
                    4'(DIV), 4'(DIVU): begin
                        pend_hi  <= hi_next;
                        pend_lo  <= lo_next;
                        pend_cls <= CLS_DIV;
                        pend_dbz <= div_by_zero;
                        count    <= DIV_LOAD;
                    end
                    4'(MTHI): hi_q <= a;
                    4'(MTLO): lo_q <= a;
                    default: ;
                endcase
            end
        end
    end

endmodule
